// File: rtl/oam_dma_master.sv
// oam_dma_master
//   Copies one 256-byte page ({page,8'h00}..{page,8'hFF}) from system RAM to
//   the OAM data port at DST_ADDR over the shared single-cycle synchronous bus.
//   Each byte is moved in three cycles:
//     RD_ADDR : present the source address
//     RD_DATA : the RAM drives the data, which is captured at the closing edge
//     WR      : write the captured byte to DST_ADDR
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   start, page : transfer request and source page (accepted only in IDLE)
//   addr        : bus address
//   data        : bus data, driven by this block only during WR
//   rw_n, cs_n  : bus direction (1 = read) and active-low select
//   busy        : engine owns the bus
//   done        : one-cycle pulse after the final write
//   byte_cnt    : index of the byte currently being moved
module oam_dma_master #(
  parameter logic [15:0] DST_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  page,
  output logic [15:0] addr,
  inout  wire  [7:0]  data,
  output logic        rw_n,
  output logic        cs_n,
  output logic        busy,
  output logic        done,
  output logic [7:0]  byte_cnt
);

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, WR} state_t;

  state_t     state;
  logic [7:0] page_q;
  logic [7:0] byte_q;
  logic       wr_en;   // registered copy of "in WR"; gates the data driver

  // Only path onto the bus is from registers; data never reaches an output.
  assign data = wr_en ? byte_q : 8'hzz;

  // Outputs are registered and set up for the state being entered, so every
  // bus signal is stable for the whole cycle of that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= 16'h0000;
      rw_n     <= 1'b1;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_cnt <= 8'h00;
      byte_q   <= 8'h00;
      page_q   <= 8'h00;
      wr_en    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            page_q   <= page;
            byte_cnt <= 8'h00;
            addr     <= {page, 8'h00};
            cs_n     <= 1'b0;
            rw_n     <= 1'b1;
            busy     <= 1'b1;
            state    <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          // Address and controls held for a second read cycle.
          state <= RD_DATA;
        end
        RD_DATA: begin
          byte_q <= data;
          addr   <= DST_ADDR;
          rw_n   <= 1'b0;
          wr_en  <= 1'b1;
          state  <= WR;
        end
        WR: begin
          wr_en <= 1'b0;
          rw_n  <= 1'b1;
          // 8-bit counter: after byte 8'hFF it wraps to 0, leaving the
          // counter cleared for IDLE; the page bits are never touched.
          byte_cnt <= byte_cnt + 8'd1;
          if (byte_cnt == 8'hFF) begin
            addr  <= 16'h0000;
            cs_n  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            addr  <= {page_q, byte_cnt + 8'd1};
            state <= RD_ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
